// File: rtl/pwm_display_pkg.sv
// rtl/pwm_display_pkg.sv - shared types and constants for the PWM motor/display controller
package pwm_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    localparam int LEVEL_MAX        = 15;
    localparam int TICKS_PER_PERIOD = 15;

    localparam logic [6:0] SEG_STOP = 7'b0111111;

    // Active-low segments {g,f,e,d,c,b,a}; entry 15 first so SEG_TABLE[v] indexes by value.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

endpackage

// File: rtl/hex_to_7seg.sv
// rtl/hex_to_7seg.sv - combinational 4-bit value to active-low seven-segment pattern
module hex_to_7seg
    import pwm_display_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_hex];

endmodule

// File: rtl/pwm_display_ctrl.sv
// rtl/pwm_display_ctrl.sv - motor PWM with level ramp, watchdog stop and hex display (ramp: PWM_DISPLAY_RAMP_EN)
module pwm_display_ctrl
    import pwm_display_pkg::*;
#(
    parameter int PRESCALE     = 195,
    parameter int RAMP_PERIODS = 4,
    parameter int WDOG_CYCLES  = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] data_in,
    input  logic       data_valid,
    output logic       data_ack,
    output logic       pwm_out,
    output logic [6:0] seg,
    output logic       wdog_trip
);

    localparam logic [15:0] PRE_LAST  = 16'(PRESCALE - 1);
    localparam logic [3:0]  TICK_LAST = 4'(TICKS_PER_PERIOD - 1);
    localparam bit          WDOG_EN   = (WDOG_CYCLES != 0);
    localparam logic [31:0] WDOG_LAST = WDOG_EN ? 32'(WDOG_CYCLES - 1) : 32'd0;

    logic [15:0] r_pre;
    logic [3:0]  r_tick;
    logic [3:0]  r_target;
    logic [3:0]  r_applied;
    logic [31:0] r_wdog;
    state_t      r_state;
    logic        r_ack;
    logic        r_pwm;
    logic        r_trip;
    logic [6:0]  r_seg;

    logic        w_tick;
    logic        w_boundary;
    logic [3:0]  w_tick_nxt;
    logic        w_expire;
    logic        w_stop_nxt;
    logic [3:0]  w_target_nxt;
    logic [3:0]  w_level_nxt;
    logic [3:0]  w_applied_nxt;
    logic [6:0]  w_seg_hex;

    assign w_tick       = (r_pre == PRE_LAST);
    assign w_boundary   = w_tick && (r_tick == TICK_LAST);
    assign w_tick_nxt   = !w_tick ? r_tick : (w_boundary ? 4'd0 : r_tick + 4'd1);

    // A sample arriving on the expiry cycle wins over the watchdog.
    assign w_expire     = WDOG_EN && (r_state != ST_STOP) && !data_valid && (r_wdog == WDOG_LAST);
    assign w_stop_nxt   = w_expire || ((r_state == ST_STOP) && !data_valid);
    assign w_target_nxt = data_valid ? data_in : (w_expire ? 4'd0 : r_target);

`ifdef PWM_DISPLAY_RAMP_EN
    localparam logic [7:0] RAMP_LAST = 8'(RAMP_PERIODS - 1);

    logic [7:0] r_ramp;
    logic       w_step;

    assign w_step = w_boundary && (r_applied != r_target) && (r_ramp == RAMP_LAST);

    always_comb begin
        w_level_nxt = r_applied;
        if (w_step) begin
            w_level_nxt = (r_applied < r_target) ? r_applied + 4'd1 : r_applied - 4'd1;
        end
    end

    // Period count toward the next step; idles at zero once the level has settled.
    always_ff @(posedge clk) begin
        if (reset || (r_applied == r_target)) begin
            r_ramp <= 8'd0;
        end else if (w_boundary) begin
            r_ramp <= (r_ramp == RAMP_LAST) ? 8'd0 : r_ramp + 8'd1;
        end
    end
`else
    logic [31:0] w_unused_ramp;

    assign w_unused_ramp = 32'(RAMP_PERIODS);
    assign w_level_nxt   = w_boundary ? r_target : r_applied;
`endif

    assign w_applied_nxt = w_expire ? 4'd0 : w_level_nxt;

    hex_to_7seg u_hex (
        .i_hex (w_applied_nxt),
        .o_seg (w_seg_hex)
    );

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre     <= 16'd0;
            r_tick    <= 4'd0;
            r_target  <= 4'd0;
            r_applied <= 4'd0;
            r_wdog    <= 32'd0;
            r_state   <= ST_IDLE;
            r_ack     <= 1'b0;
            r_pwm     <= 1'b0;
            r_trip    <= 1'b0;
            r_seg     <= SEG_TABLE[0];
        end else begin
            r_pre     <= w_tick ? 16'd0 : r_pre + 16'd1;
            r_tick    <= w_tick_nxt;
            r_target  <= w_target_nxt;
            r_applied <= w_applied_nxt;
            r_wdog    <= (!WDOG_EN || data_valid || w_stop_nxt) ? 32'd0 : r_wdog + 32'd1;
            r_ack     <= data_valid;
            r_pwm     <= (w_tick_nxt < w_applied_nxt);
            r_trip    <= w_stop_nxt;
            r_seg     <= w_stop_nxt ? SEG_STOP : w_seg_hex;
            if (w_stop_nxt) begin
                r_state <= ST_STOP;
            end else if (w_applied_nxt == w_target_nxt) begin
                r_state <= ST_IDLE;
            end else if (w_applied_nxt < w_target_nxt) begin
                r_state <= ST_UP;
            end else begin
                r_state <= ST_DOWN;
            end
        end
    end

    assign data_ack  = r_ack;
    assign pwm_out   = r_pwm;
    assign seg       = r_seg;
    assign wdog_trip = r_trip;

endmodule

// File: tb/tb_pwm_display_ctrl.sv
// tb/tb_pwm_display_ctrl.sv - self-checking bench for pwm_display_ctrl against a time-based reference model
module tb_pwm_display_ctrl;

    localparam int P      = 2;
    localparam int R      = 1;
    localparam int W      = 100;
    localparam int PERIOD = 15 * P;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] data_in = 4'd0;
    logic       data_valid = 1'b0;
    logic       data_ack;
    logic       pwm_out;
    logic [6:0] seg;
    logic       wdog_trip;

    int n_vec = 0;
    int n_err = 0;

    int m_n, m_target, m_applied, m_since;
    bit m_stop, m_ack;

    pwm_display_ctrl #(
        .PRESCALE     (P),
        .RAMP_PERIODS (R),
        .WDOG_CYCLES  (W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .pwm_out    (pwm_out),
        .seg        (seg),
        .wdog_trip  (wdog_trip)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input int v);
        case (v)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
            12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    function automatic logic exp_pwm();
        return ((m_n / P) % 15) < m_applied;
    endfunction

    function automatic logic [6:0] exp_seg();
        return m_stop ? 7'b0111111 : hex7(m_applied);
    endfunction

    // Model: level state as a function of edges since reset; boundaries every PERIOD edges.
    task automatic model_edge(input logic rst, input logic dv, input logic [3:0] din);
        int old_target;
        if (rst) begin
            m_n = 0; m_target = 0; m_applied = 0; m_since = 0; m_stop = 0; m_ack = 0;
            return;
        end
        old_target = m_target;
        m_n++;
        if (!m_stop && !dv && m_since == W - 1) begin
            m_target = 0; m_applied = 0; m_stop = 1; m_since = 0;
        end else begin
            if (m_n % PERIOD == 0) begin
`ifdef PWM_DISPLAY_RAMP_EN
                if (m_applied < old_target) m_applied++;
                else if (m_applied > old_target) m_applied--;
`else
                m_applied = old_target;
`endif
            end
            if (dv) begin
                m_target = din; m_stop = 0; m_since = 0;
            end else if (!m_stop) begin
                m_since++;
            end
        end
        m_ack = dv;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(reset, data_valid, data_in);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; data_valid = 1'b1; data_in = 4'd7;
        repeat (3) step();
        data_valid = 1'b0;
        n_vec += 4;
        if (pwm_out !== 1'b0) begin n_err++; $display("FAIL reset_pwm got %b want 0", pwm_out); end
        if (data_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got %b want 0", data_ack); end
        if (wdog_trip !== 1'b0) begin n_err++; $display("FAIL reset_trip got %b want 0", wdog_trip); end
        if (seg !== 7'b1000000) begin n_err++; $display("FAIL reset_seg got %b want 1000000", seg); end
        reset = 1'b0;
        step();
        n_vec++;
        if (data_ack !== 1'b0) begin n_err++; $display("FAIL reset_dv_ignored got %b want 0", data_ack); end
    endtask

    task automatic test_full_level();
        int guard;
        data_valid = 1'b1; data_in = 4'd15;
        step();
        data_valid = 1'b0;
        n_vec++;
        if (data_ack !== 1'b1) begin n_err++; $display("FAIL full_ack got %b want 1", data_ack); end
        step();
        n_vec++;
        if (data_ack !== 1'b0) begin n_err++; $display("FAIL full_ack_pulse got %b want 0", data_ack); end
        guard = 0;
        while (!(m_applied == 15 && m_n % PERIOD == 0) && guard < 2 * PERIOD) begin step(); guard++; end
        n_vec++;
        if (guard >= 2 * PERIOD) begin n_err++; $display("FAIL full_timeout got %0d want <%0d", guard, 2 * PERIOD); end
        for (int i = 0; i < PERIOD; i++) begin
            n_vec++;
            if (pwm_out !== 1'b1) begin n_err++; $display("FAIL full_pwm_high cyc %0d got %b want 1", i, pwm_out); end
            step();
        end
    endtask

    task automatic test_duty_level5();
        int guard, highs;
        data_valid = 1'b1; data_in = 4'd5;
        step();
        data_valid = 1'b0;
        guard = 0;
        while (!(m_applied == 5 && m_n % PERIOD == 0) && guard < 2 * PERIOD) begin step(); guard++; end
        n_vec++;
        if (guard >= 2 * PERIOD) begin n_err++; $display("FAIL duty_timeout got %0d want <%0d", guard, 2 * PERIOD); end
        highs = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (pwm_out === 1'b1) highs++;
            step();
        end
        n_vec += 2;
        if (highs != 5 * P) begin n_err++; $display("FAIL duty5_high got %0d want %0d", highs, 5 * P); end
        if (seg !== 7'b0010010) begin n_err++; $display("FAIL duty5_seg got %b want 0010010", seg); end
    endtask

    task automatic test_watchdog();
        data_valid = 1'b1; data_in = 4'd9;
        step();
        data_valid = 1'b0;
        for (int i = 0; i < W - 1; i++) begin
            step();
            n_vec++;
            if (pwm_out !== exp_pwm()) begin n_err++; $display("FAIL wdog_pwm cyc %0d got %b want %b", i, pwm_out, exp_pwm()); end
        end
        n_vec++;
        if (wdog_trip !== 1'b0) begin n_err++; $display("FAIL wdog_early got %b want 0", wdog_trip); end
        step();
        n_vec += 3;
        if (wdog_trip !== 1'b1) begin n_err++; $display("FAIL wdog_trip got %b want 1", wdog_trip); end
        if (pwm_out !== 1'b0) begin n_err++; $display("FAIL wdog_pwm_low got %b want 0", pwm_out); end
        if (seg !== 7'b0111111) begin n_err++; $display("FAIL wdog_seg got %b want 0111111", seg); end
        repeat (5) step();
        data_valid = 1'b1; data_in = 4'd4;
        step();
        data_valid = 1'b0;
        n_vec += 3;
        if (wdog_trip !== 1'b0) begin n_err++; $display("FAIL wdog_clear got %b want 0", wdog_trip); end
        if (data_ack !== 1'b1) begin n_err++; $display("FAIL wdog_clear_ack got %b want 1", data_ack); end
        if (seg !== exp_seg()) begin n_err++; $display("FAIL wdog_clear_seg got %b want %b", seg, exp_seg()); end
    endtask

    task automatic test_wdog_coincide();
        data_valid = 1'b1; data_in = 4'd9;
        step();
        data_valid = 1'b0;
        repeat (W - 1) step();
        data_valid = 1'b1; data_in = 4'd6;
        step();
        data_valid = 1'b0;
        n_vec += 2;
        if (wdog_trip !== 1'b0) begin n_err++; $display("FAIL coincide_trip got %b want 0", wdog_trip); end
        if (data_ack !== 1'b1) begin n_err++; $display("FAIL coincide_ack got %b want 1", data_ack); end
        step();
        n_vec++;
        if (wdog_trip !== 1'b0) begin n_err++; $display("FAIL coincide_after got %b want 0", wdog_trip); end
    endtask

    task automatic test_reset_midramp();
        data_valid = 1'b1; data_in = 4'd12;
        step();
        data_valid = 1'b0;
        repeat (PERIOD + 7) step();
        reset = 1'b1; data_valid = 1'b1; data_in = 4'd3;
        step();
        data_valid = 1'b0;
        n_vec += 4;
        if (pwm_out !== 1'b0) begin n_err++; $display("FAIL midreset_pwm got %b want 0", pwm_out); end
        if (data_ack !== 1'b0) begin n_err++; $display("FAIL midreset_ack got %b want 0", data_ack); end
        if (wdog_trip !== 1'b0) begin n_err++; $display("FAIL midreset_trip got %b want 0", wdog_trip); end
        if (seg !== 7'b1000000) begin n_err++; $display("FAIL midreset_seg got %b want 1000000", seg); end
        reset = 1'b0;
        step();
        n_vec++;
        if (data_ack !== 1'b0) begin n_err++; $display("FAIL midreset_dv_ignored got %b want 0", data_ack); end
    endtask

`ifdef PWM_DISPLAY_RAMP_EN
    task automatic test_ramp();
        int lv;
        int seq[13] = '{1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3};
        data_valid = 1'b1; data_in = 4'd8;
        step();
        data_valid = 1'b0;
        for (int k = 0; k < 13; k++) begin
            if (k == 8) begin
                data_valid = 1'b1; data_in = 4'd3;
            end
            step();
            data_valid = 1'b0;
            for (int g = 0; g < PERIOD && m_n % PERIOD != 0; g++) begin
                if (g == PERIOD / 2) begin data_valid = 1'b1; data_in = (k < 8) ? 4'd8 : 4'd3; end
                step();
                data_valid = 1'b0;
            end
            lv = seq[k];
            n_vec++;
            if (seg !== hex7(lv)) begin n_err++; $display("FAIL ramp_step %0d got %b want %b", k, seg, hex7(lv)); end
        end
    endtask
`endif

    task automatic test_random();
        int r;
        for (int i = 0; i < 1600; i++) begin
            r = $urandom_range(0, 599);
            reset = (r == 0);
            data_valid = (i < 800) ? (r % 25 == 1) : (r % 150 == 1);
            data_in = 4'($urandom_range(0, 15));
            step();
            reset = 1'b0; data_valid = 1'b0;
            n_vec += 4;
            if (pwm_out !== exp_pwm()) begin n_err++; $display("FAIL rand_pwm n=%0d got %b want %b", m_n, pwm_out, exp_pwm()); end
            if (seg !== exp_seg()) begin n_err++; $display("FAIL rand_seg n=%0d got %b want %b", m_n, seg, exp_seg()); end
            if (data_ack !== m_ack) begin n_err++; $display("FAIL rand_ack n=%0d got %b want %b", m_n, data_ack, m_ack); end
            if (wdog_trip !== m_stop) begin n_err++; $display("FAIL rand_trip n=%0d got %b want %b", m_n, wdog_trip, m_stop); end
        end
    endtask

    initial begin
        test_reset();
        test_full_level();
        test_duty_level5();
        test_watchdog();
        test_wdog_coincide();
        test_reset_midramp();
`ifdef PWM_DISPLAY_RAMP_EN
        test_ramp();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
